// File: rtl/axi4_lite_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_arb_pkg - shared types, AXI response codes, round-robin pick (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_WR_REQ = 3'd2,
    S_WR_RSP = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_RSP = 3'd5,
    S_RESP   = 3'd6
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // First requester at or after (last + 1) mod n; returns 0 when nothing requests.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k <= n) begin
        idx = (32'(last) + k) % n;
        if (!found && req[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite.sv
// ---------------------------------------------------------------------------
// axi4_lite - AXI4-Lite bundle with master/slave views (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter - combinational round-robin grant, one-hot plus index (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_grant_i,
  input  logic                     enable_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [2:0] w_pick;

  always_comb begin
    w_pick      = rr_pick(8'(req_i), 3'(last_grant_i), N_REQ);
    grant_idx_o = w_pick[IDX_W-1:0];
    grant_o     = '0;
    if (enable_i && (|req_i)) grant_o[grant_idx_o] = 1'b1;
  end
endmodule

`default_nettype wire

// File: rtl/axi4_lite_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_mem_arbiter - shares one AXI4-Lite slave among N_REQ requesters (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_lite_mem_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  axi4_lite.master                     axi4_m
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, last_grant_q;
  logic [N_REQ-1:0]        grant_oh_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    aw_done_q, w_done_q, err_q;

  logic [N_REQ-1:0]        w_arb_oh;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_aw_hs, w_w_hs;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (state_q == S_IDLE),
    .grant_o      (w_arb_oh),
    .grant_idx_o  (w_arb_idx)
  );

  assign w_aw_hs = axi4_m.awvalid && axi4_m.awready;
  assign w_w_hs  = axi4_m.wvalid && axi4_m.wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req_valid) state_d = S_ARB;
      S_ARB:    state_d = req_we[grant_q] ? S_WR_REQ : S_RD_REQ;
      // AW and W may complete in different cycles; the done flags remember the earlier one.
      S_WR_REQ: if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) state_d = S_WR_RSP;
      S_WR_RSP: if (axi4_m.bvalid) state_d = S_RESP;
      S_RD_REQ: if (axi4_m.arready) state_d = S_RD_RSP;
      S_RD_RSP: if (axi4_m.rvalid) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q    <= w_arb_idx;
            grant_oh_q <= w_arb_oh;
          end
        end
        S_ARB: begin
          last_grant_q <= grant_q;
          addr_q       <= req_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_q      <= req_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_q      <= req_wstrb[int'(grant_q)*STRB_W +: STRB_W];
          rdata_q      <= '0;
          err_q        <= 1'b0;
          aw_done_q    <= 1'b0;
          w_done_q     <= 1'b0;
        end
        S_WR_REQ: begin
          if (w_aw_hs) aw_done_q <= 1'b1;
          if (w_w_hs)  w_done_q  <= 1'b1;
        end
        S_WR_RSP: if (axi4_m.bvalid) err_q <= (axi4_m.bresp != RESP_OKAY);
        S_RD_RSP: begin
          if (axi4_m.rvalid) begin
            rdata_q <= axi4_m.rdata;
            err_q   <= (axi4_m.rresp != RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (state_q == S_ARB)  ? grant_oh_q : '0;
  assign rsp_valid      = (state_q == S_RESP) ? grant_oh_q : '0;
  assign rsp_rdata      = (state_q == S_RESP) ? rdata_q : '0;
  assign rsp_err        = (state_q == S_RESP) && err_q;

  assign axi4_m.awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign axi4_m.wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign axi4_m.bready  = (state_q == S_WR_RSP);
  assign axi4_m.arvalid = (state_q == S_RD_REQ);
  assign axi4_m.rready  = (state_q == S_RD_RSP);
  assign axi4_m.awaddr  = addr_q;
  assign axi4_m.araddr  = addr_q;
  assign axi4_m.wdata   = wdata_q;
  assign axi4_m.wstrb   = wstrb_q;

  // Requesters must hold their command until accepted.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req_hold_chk
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
  end
endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_mem_arbiter - scoreboard bench with a small AXI4-Lite memory slave (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi4_lite_mem_arbiter;
  import axi4_lite_arb_pkg::*;

  localparam int N = 4;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int   total = 0;
  int   bad   = 0;
  int   exp_grant[$];
  rsp_t exp_rsp[$];
  int   reissue[N];

  axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if ();

  axi4_lite_mem_arbiter #(.N_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi4_m    (axi_if)
  );

  always #5 clk = ~clk;

  // Memory slave with programmable AW/W ready delays and forced read error.
  logic [31:0] smem [16];
  logic        mem_inited = 1'b0;
  int          aw_dly = 0, w_dly = 0, aw_wait, w_wait;
  logic        rd_err = 1'b0;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;

  assign axi_if.awready = !aw_got && (aw_wait >= aw_dly);
  assign axi_if.wready  = !w_got && (w_wait >= w_dly);
  assign axi_if.bvalid  = aw_got && w_got;
  assign axi_if.bresp   = RESP_OKAY;
  assign axi_if.arready = !r_pend;
  assign axi_if.rvalid  = r_pend;
  assign axi_if.rdata   = r_pend ? smem[ar_addr_l[3:0]] : 32'h0;
  assign axi_if.rresp   = rd_err ? RESP_SLVERR : RESP_OKAY;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_wait <= 0; w_wait <= 0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; ar_addr_l <= '0;
      if (!mem_inited) begin
        for (int k = 0; k < 16; k++) smem[k] <= 32'hC0DE_0000 | 32'(k);
        mem_inited <= 1'b1;
      end
    end else begin
      if (axi_if.awvalid && axi_if.awready) begin
        aw_got <= 1'b1; aw_addr_l <= axi_if.awaddr; aw_wait <= 0;
      end else if (axi_if.awvalid) aw_wait <= aw_wait + 1;
      if (axi_if.wvalid && axi_if.wready) begin
        w_got <= 1'b1; w_data_l <= axi_if.wdata; w_strb_l <= axi_if.wstrb; w_wait <= 0;
      end else if (axi_if.wvalid) w_wait <= w_wait + 1;
      if (aw_got && w_got && axi_if.bready) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) smem[aw_addr_l[3:0]][8*b +: 8] <= w_data_l[8*b +: 8];
      end
      if (axi_if.arvalid && axi_if.arready) begin
        r_pend <= 1'b1; ar_addr_l <= axi_if.araddr;
      end else if (r_pend && axi_if.rready) r_pend <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input int i, input logic [31:0] d, input logic e, input int lat);
    rsp_t r;
    r.idx = i; r.rdata = d; r.err = e; r.lat = lat;
    exp_grant.push_back(i);
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_we[i]            = we;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]  = s;
    req_valid[i]         = 1'b1;
  endtask

  // Drops each requester's valid after the accept edge and waits for all responses.
  task automatic run(input int max_cycles);
    int cyc;
    logic [N-1:0] acc;
    cyc = 0;
    while ((req_valid != '0 || exp_rsp.size() != 0) && cyc < max_cycles) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          if (reissue[i] > 0) reissue[i]--;
          else req_valid[i] = 1'b0;
        end
      cyc++;
    end
    if (cyc >= max_cycles) chk("run_timeout", 32'(cyc), 32'(max_cycles - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic monitor();
    int   cyc, last_rdy, g;
    logic aw_p, w_p, ar_p;
    rsp_t e;
    cyc = 0; last_rdy = 0; aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        last_rdy = cyc;
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'h0);
        else begin
          g = exp_grant.pop_front();
          chk("grant", 32'(req_ready), 32'(1) << g);
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_who", 32'(rsp_valid), 32'(1) << e.idx);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.lat > 0) chk("rsp_latency", 32'(cyc - last_rdy), 32'(e.lat));
        end
      end
      if (rst) begin
        aw_p = 1'b0; w_p = 1'b0; ar_p = 1'b0;
      end else begin
        if (aw_p) chk("awvalid_hold", 32'(axi_if.awvalid), 32'h1);
        if (w_p)  chk("wvalid_hold", 32'(axi_if.wvalid), 32'h1);
        if (ar_p) chk("arvalid_hold", 32'(axi_if.arvalid), 32'h1);
        aw_p = axi_if.awvalid && !axi_if.awready;
        w_p  = axi_if.wvalid && !axi_if.wready;
        ar_p = axi_if.arvalid && !axi_if.arready;
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_axi_valids"}, 32'({axi_if.awvalid, axi_if.wvalid, axi_if.bready,
                                    axi_if.arvalid, axi_if.rready}), 32'h0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int i = 0; i < N; i++) reissue[i] = 0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_awaddr", axi_if.awaddr, 32'h0);
    chk("reset_wdata", axi_if.wdata, 32'h0);
    chk("reset_wstrb", 32'(axi_if.wstrb), 32'h0);
    chk("reset_araddr", axi_if.araddr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write then read, plus a partial-strobe write.
    expect_txn(0, 32'h0, 1'b0, 3);
    issue(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    run(40);
    expect_txn(0, 32'hDEAD_BEEF, 1'b0, 3);
    issue(0, 1'b0, 32'h4, 32'h0, 4'h0);
    run(40);
    expect_txn(1, 32'h0, 1'b0, 3);
    issue(1, 1'b1, 32'h5, 32'h1234_5678, 4'h3);
    run(40);
    chk("strobe_merge", smem[5], 32'hC0DE_5678);

    // Contention between req0 and req1 from a fresh pointer.
    do_reset();
    expect_txn(0, 32'h0, 1'b0, 3);
    expect_txn(1, 32'h0, 1'b0, 3);
    issue(0, 1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF);
    issue(1, 1'b1, 32'h2, 32'h5555_5555, 4'hF);
    run(60);
    expect_txn(0, 32'hAAAA_AAAA, 1'b0, 3);
    expect_txn(1, 32'h5555_5555, 1'b0, 3);
    issue(0, 1'b0, 32'h1, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h2, 32'h0, 4'h0);
    run(60);

    // Rotation with all four requesters reading continuously.
    do_reset();
    expect_txn(0, 32'hC0DE_0008, 1'b0, 3);
    expect_txn(1, 32'hC0DE_0009, 1'b0, 3);
    expect_txn(2, 32'hC0DE_000A, 1'b0, 3);
    expect_txn(3, 32'hC0DE_000B, 1'b0, 3);
    expect_txn(0, 32'hC0DE_0008, 1'b0, 3);
    expect_txn(1, 32'hC0DE_0009, 1'b0, 3);
    reissue[0] = 1; reissue[1] = 1;
    for (int i = 0; i < N; i++) issue(i, 1'b0, 32'(8 + i), 32'h0, 4'h0);
    run(120);

    // Slave backpressure on AW (3 cycles) and W (1 cycle).
    aw_dly = 3; w_dly = 1;
    expect_txn(2, 32'h0, 1'b0, 0);
    issue(2, 1'b1, 32'h3, 32'hF0F0_F0F0, 4'hF);
    run(60);
    aw_dly = 0; w_dly = 0;
    expect_txn(3, 32'hF0F0_F0F0, 1'b0, 3);
    issue(3, 1'b0, 32'h3, 32'h0, 4'h0);
    run(40);

    // SLVERR on read.
    rd_err = 1'b1;
    expect_txn(0, 32'hDEAD_BEEF, 1'b1, 3);
    issue(0, 1'b0, 32'h4, 32'h0, 4'h0);
    run(40);
    rd_err = 1'b0;

    // Reset while waiting in the B phase.
    exp_grant.push_back(0);
    issue(0, 1'b1, 32'h6, 32'h1111_2222, 4'hF);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi_if.bready && n < 20);
    chk("reached_wr_rsp", 32'(axi_if.bready), 32'h1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_write", smem[6], 32'hC0DE_0006);
    expect_txn(0, 32'hC0DE_5678, 1'b0, 3);
    expect_txn(2, 32'hDEAD_BEEF, 1'b0, 3);
    issue(2, 1'b0, 32'h4, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h5, 32'h0, 4'h0);
    run(60);

    chk("grants_left", 32'(exp_grant.size()), 32'h0);
    chk("rsps_left", 32'(exp_rsp.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi4_lite_mem_arbiter.md
# axi4_lite_mem_arbiter

Round-robin arbiter and AXI4-Lite master sequencer that shares one `axi4_lite_mem` slave between `N_REQ` simple command requesters. Each requester issues a single read or write through a valid/ready command port. The block serialises these commands onto the `axi4_lite` interface, one transaction outstanding at a time, and returns data and status on a per-requester response pulse. It sits between on-chip engines and the shared AXI4-Lite memory.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: command address width, driven onto `awaddr`/`araddr`.
- `DATA_WIDTH`, 32: data width; must match the `axi4_lite` interface instance.
- `clk` in 1: single clock; the `axi4_lite` interface instance is clocked by the same net.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: command valid per requester.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `req_we` in N_REQ: 1 = write, 0 = read.
- `req_addr` in N_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in N_REQ*DATA_WIDTH: packed write data.
- `req_wstrb` in N_REQ*DATA_WIDTH/8: packed write strobes.
- `rsp_valid` out N_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
- `rsp_err` out 1: 1 when the BRESP/RRESP value was not OKAY.
- `axi4_m` interface `axi4_lite.master`: AW, W, B, AR and R channels.

## Operation
- FSM states:
  - IDLE: waits for a command.
  - ARB: the cycle in which a command is accepted.
  - WR_REQ: AW and W phase.
  - WR_RSP: B phase.
  - RD_REQ: AR phase.
  - RD_RSP: R phase.
  - RESP: completion pulse to the requester.
- Arbitration:
  - Evaluated in IDLE whenever any `req_valid` is high.
  - Grant goes to the first requester at or after (`last_grant` + 1) mod N_REQ.
  - `last_grant` resets to N_REQ-1, so requester 0 wins first.
- Accept (ARB):
  - `req_ready[g]` = 1 for exactly one cycle.
  - we/addr/wdata/wstrb are latched into internal registers.
  - `last_grant` ← g.
- Write sequence:
  - WR_REQ asserts `awvalid` and `wvalid` together, each from the registered command.
  - Each valid drops independently on its own handshake.
  - Leave WR_REQ when both handshakes have completed, including the case where they complete in different cycles.
  - WR_RSP holds `bready` = 1; on `bvalid`, capture `bresp` and go to RESP.
- Read sequence:
  - RD_REQ asserts `arvalid` until `arready`.
  - RD_RSP holds `rready` = 1; on `rvalid`, capture `rdata` and `rresp` and go to RESP.
- RESP:
  - `rsp_valid[g]` = 1 for one cycle; `rsp_rdata` and `rsp_err` are valid in that cycle.
  - Next state is IDLE.
- Requester obligation: hold `req_valid` and command fields stable until `req_ready`. Non-granted requesters wait and are never dropped.
- Once asserted, no AXI valid is deasserted before its handshake (except by reset).

## Timing
- Reset value 0 for all outputs: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `awvalid`, `wvalid`, `bready`, `arvalid`, `rready`, `awaddr`, `wdata`, `wstrb`, `araddr`.
- FSM resets to IDLE.
- Cycle numbering, with the slave ready immediately:
  - c0: IDLE sees `req_valid`.
  - c1: ARB, `req_ready`.
  - c2: AW/W (or AR) valid.
  - c3: earliest `bvalid`/`rvalid` accepted.
  - c4: `rsp_valid`.
  - c5: IDLE; the next grant is possible from this cycle.
- Minimum spacing is 5 cycles per transaction. There is no pipelining across transactions.
- Simultaneous `req_valid` from all requesters is served in strict rotation with no starvation. Worst-case wait is (N_REQ-1) transactions.
- `req_valid` falling without `req_ready` is a requester protocol violation; the behaviour is undefined and is flagged by an assertion.
- Reset mid-transaction:
  - All outputs clear asynchronously and the in-flight command is discarded.
  - No `rsp_valid` is issued for it.
  - `last_grant` returns to N_REQ-1.

## Structure
- Package `axi4_lite_arb_pkg` contains:
  - the state enum;
  - localparams `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10;
  - a function computing the round-robin grant index.
- One sub-module, `rr_arbiter`:
  - parameterised by N_REQ;
  - inputs: request vector, `last_grant`, `enable`;
  - outputs: one-hot grant and grant index; purely combinational.
- Pointer and FSM registers live in the top module.

## Test plan
- Single write then read. Req0 writes 0x0000_0004 ← 0xDEAD_BEEF, wstrb 0xF, then reads 0x0000_0004. Required: `rsp_valid[0]` twice, the second with `rsp_rdata` = 0xDEAD_BEEF and `rsp_err` = 0, and `rsp_valid` exactly 3 cycles after `req_ready` in each transaction.
- Contention. Req0 and req1 both hold writes (0x1 ← 0xAAAA_AAAA and 0x2 ← 0x5555_5555) from the same cycle. Required: req0 granted first, req1 next. Reading both back returns the written values.
- Rotation fairness with N_REQ = 4. All four requesters continuously request reads. Required grant order 0,1,2,3,0,1, with no requester granted twice before the others are served.
- Slave backpressure. Bench wrapper delays `awready` 3 cycles and `wready` 1 cycle. Required: `awvalid` and `wvalid` are held until their own handshakes, and data 0xF0F0_F0F0 lands at address 0x3.
- Error response. Slave returns `rresp` = SLVERR. Required: `rsp_err` = 1 and `rsp_valid` is a single pulse.
- Reset mid-write. Assert `rst` in WR_RSP. Required: all AXI valids and `rsp_valid` are 0 in the same cycle, no response pulse appears, and the next grant after release goes to req0.
